fetch_unit: RTL

//  Front-end producer for the instruction queue drained by the backend. Owns the fetch PC,

---
 rtl/cpu_params.sv | 17 +
 rtl/fetch_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/cpu_params.sv
// rtl/cpu_params.sv - shared CPU front-end types and helpers
package cpu_params;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DISCARD} fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch feeding the instruction queue
module fetch_unit
  import cpu_params::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        backend_flush,
  input  logic [31:0] backend_redirect_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        fifo_valid,
  input  logic        fifo_ready,
  output logic [31:0] fifo_pc,
  output logic [31:0] fifo_inst,
  output logic        fifo_flush
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n, pc_inc;
  logic [31:0]  hold_inst, hold_n;
  logic         issue;
  fetch_pkt_t   pkt;

  assign pc_inc = pc + PC_STEP;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    hold_n     = hold_inst;
    issue      = 1'b0;
    imem_addr  = pc;
    fifo_valid = 1'b0;
    pkt        = '{pc: pc, inst: hold_inst};

    case (state)
      REQ: begin
        issue   = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (imem_resp) begin
          fifo_valid = 1'b1;
          pkt.inst   = imem_rdata;
          // Push and next read share the response cycle, giving zero bubbles.
          if (fifo_ready) begin
            issue     = 1'b1;
            imem_addr = pc_inc;
            pc_n      = pc_inc;
          end else begin
            hold_n  = imem_rdata;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        fifo_valid = 1'b1;
        if (fifo_ready) begin
          issue     = 1'b1;
          imem_addr = pc_inc;
          pc_n      = pc_inc;
          state_n   = WAIT;
        end
      end
      DISCARD: begin
        if (imem_resp) state_n = REQ;
      end
      default: state_n = REQ;
    endcase

    // A read still in flight must be absorbed before the redirected fetch starts.
    if (backend_flush) begin
      issue      = 1'b0;
      fifo_valid = 1'b0;
      pc_n       = align_pc(backend_redirect_pc);
      hold_n     = '0;
      state_n    = (((state == WAIT) || (state == DISCARD)) && !imem_resp) ? DISCARD : REQ;
    end

    if (rst) begin
      issue      = 1'b0;
      fifo_valid = 1'b0;
    end
  end

  assign imem_rmask = issue ? 4'hF : 4'h0;
  assign fifo_flush = backend_flush & ~rst;
  assign fifo_pc    = pkt.pc;
  assign fifo_inst  = pkt.inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      hold_inst <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      hold_inst <= hold_n;
    end
  end

endmodule
